// File: rtl/tlb_lookup_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tlb_lookup_if : lookup, entry-write and INVTLB bundle for tlb_lookup |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface tlb_lookup_if #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = $clog2(TLBNUM)
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_vaddr;
  logic [9:0]       req_asid;
  logic             rsp_valid;
  logic             rsp_hit;
  logic [IDX_W-1:0] rsp_idx;
  logic [19:0]      rsp_pfn;
  logic             rsp_v;
  logic             rsp_d;
  logic [1:0]       rsp_mat;
  logic [1:0]       rsp_plv;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [82:0]      wr_entry;
  logic             inv_valid;
  logic [2:0]       inv_op;
  logic [9:0]       inv_asid;
  logic [18:0]      inv_vppn;
  logic             inv_busy;

  modport slave (
    input  req_valid, req_vaddr, req_asid,
    output req_ready,
    output rsp_valid, rsp_hit, rsp_idx, rsp_pfn, rsp_v, rsp_d, rsp_mat, rsp_plv,
    input  wr_en, wr_idx, wr_entry,
    input  inv_valid, inv_op, inv_asid, inv_vppn,
    output inv_busy
  );

  modport master (
    output req_valid, req_vaddr, req_asid,
    input  req_ready,
    input  rsp_valid, rsp_hit, rsp_idx, rsp_pfn, rsp_v, rsp_d, rsp_mat, rsp_plv,
    output wr_en, wr_idx, wr_entry,
    output inv_valid, inv_op, inv_asid, inv_vppn,
    input  inv_busy
  );
endinterface
`default_nettype wire

// File: rtl/tlb_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tlb_lookup : fully-associative double-page TLB search, one-cycle     |
// |              registered response, entry writes and INVTLB sweep      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tlb_lookup #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = $clog2(TLBNUM)
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  tlb_lookup_if.slave       bus
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [9:0]       asid_q, asid_d;
  logic [18:0]      vppn_q, vppn_d;

  // Only e needs a reset; the remaining entry fields are qualified by it.
  logic [TLBNUM-1:0] e_q;
  logic [81:0]       ent_q [TLBNUM];

  logic             rsp_valid_q, rsp_hit_q;
  logic [IDX_W-1:0] rsp_idx_q;
  logic [25:0]      rsp_page_q;

  logic             busy, wr_fire, inv_start, accept, clr;
  logic             lk_hit;
  logic [IDX_W-1:0] lk_idx;
  logic [25:0]      lk_page;
  logic [81:0]      sw_ent;
  logic             unused_vaddr_lo;

  assign busy      = (state_q == S_SWEEP);
  assign wr_fire   = bus.wr_en & ~busy;
  assign inv_start = bus.inv_valid & ~busy & (bus.inv_op != 3'd7);
  assign accept    = bus.req_valid & ~busy;
  assign unused_vaddr_lo = ^bus.req_vaddr[11:0];

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    lk_hit  = 1'b0;
    lk_idx  = '0;
    lk_page = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (e_q[i] && (ent_q[i][81:63] == bus.req_vaddr[31:13]) &&
          (ent_q[i][62] || (ent_q[i][61:52] == bus.req_asid))) begin
        lk_hit  = 1'b1;
        lk_idx  = IDX_W'(i);
        lk_page = bus.req_vaddr[12] ? ent_q[i][25:0] : ent_q[i][51:26];
      end
    end
  end

  always_comb begin
    sw_ent = ent_q[cnt_q];
    case (op_q)
      3'd0, 3'd1: clr = 1'b1;
      3'd2:       clr = sw_ent[62];
      3'd3:       clr = ~sw_ent[62];
      3'd4:       clr = ~sw_ent[62] & (sw_ent[61:52] == asid_q);
      3'd5:       clr = ~sw_ent[62] & (sw_ent[61:52] == asid_q) & (sw_ent[81:63] == vppn_q);
      3'd6:       clr = (sw_ent[62] | (sw_ent[61:52] == asid_q)) & (sw_ent[81:63] == vppn_q);
      default:    clr = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    asid_d  = asid_q;
    vppn_d  = vppn_q;
    case (state_q)
      S_IDLE: begin
        if (inv_start) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
          op_d    = bus.inv_op;
          asid_d  = bus.inv_asid;
          vppn_d  = bus.inv_vppn;
        end
      end
      S_SWEEP: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(TLBNUM - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      asid_q  <= '0;
      vppn_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      asid_q  <= asid_d;
      vppn_q  <= vppn_d;
    end
  end

  // Writes are blocked while busy, so a write and a sweep clear never collide.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      e_q <= '0;
    end else begin
      if (wr_fire)     e_q[bus.wr_idx] <= bus.wr_entry[82];
      if (busy && clr) e_q[cnt_q]      <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) ent_q[bus.wr_idx] <= bus.wr_entry[81:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_page_q  <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_hit_q  <= lk_hit;
        rsp_idx_q  <= lk_idx;
        rsp_page_q <= lk_page;
      end
    end
  end

  assign bus.req_ready = ~busy;
  assign bus.inv_busy  = busy;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hit   = rsp_hit_q;
  assign bus.rsp_idx   = rsp_idx_q;
  assign bus.rsp_pfn   = rsp_page_q[25:6];
  assign bus.rsp_v     = rsp_page_q[5];
  assign bus.rsp_d     = rsp_page_q[4];
  assign bus.rsp_mat   = rsp_page_q[3:2];
  assign bus.rsp_plv   = rsp_page_q[1:0];

endmodule
`default_nettype wire

// File: tb/tb_tlb_lookup.sv
`default_nettype none
// Self-checking bench for tlb_lookup: directed scenarios plus randomized
// traffic compared against a table-level reference model.
module tb_tlb_lookup;
  localparam int N  = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  tlb_lookup_if #(.TLBNUM(N)) bus ();
  tlb_lookup #(.TLBNUM(N)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int checks = 0;
  int passed = 0;

  logic [82:0] m_ent [N];
  logic [18:0] vpool [4] = '{19'h12345, 19'h0ABCD, 19'h7FFFF, 19'h00001};
  logic [9:0]  apool [4] = '{10'h005, 10'h007, 10'h008, 10'h3FF};

  logic [30:0] dut_rsp;
  assign dut_rsp = {bus.rsp_hit, bus.rsp_idx, bus.rsp_pfn, bus.rsp_v, bus.rsp_d, bus.rsp_mat, bus.rsp_plv};

  // Result packed as {hit, idx, pfn, v, d, mat, plv}; first matching index wins.
  function automatic logic [30:0] ref_lookup(input logic [31:0] va, input logic [9:0] asid);
    logic [82:0] e;
    for (int i = 0; i < N; i++) begin
      e = m_ent[i];
      if (e[82] && e[81:63] == va[31:13] && (e[62] || e[61:52] == asid))
        return {1'b1, 4'(i), (va[12] ? e[25:0] : e[51:26])};
    end
    return '0;
  endfunction

  function automatic logic inv_cond(input logic [2:0] op, input logic [82:0] e,
                                    input logic [9:0] asid, input logic [18:0] vppn);
    logic g, am, vm;
    g  = e[62];
    am = (e[61:52] == asid);
    vm = (e[81:63] == vppn);
    case (op)
      3'd0, 3'd1: return 1'b1;
      3'd2:       return g;
      3'd3:       return !g;
      3'd4:       return !g && am;
      3'd5:       return !g && am && vm;
      3'd6:       return (g || am) && vm;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic void model_inv(input logic [2:0] op, input logic [9:0] asid, input logic [18:0] vppn);
    for (int i = 0; i < N; i++)
      if (inv_cond(op, m_ent[i], asid, vppn)) m_ent[i][82] = 1'b0;
  endfunction

  function automatic logic [82:0] mk(input logic e, input logic [18:0] vppn, input logic g,
                                     input logic [9:0] asid, input logic [25:0] p0, input logic [25:0] p1);
    return {e, vppn, g, asid, p0, p1};
  endfunction

  function automatic logic [82:0] rand_ent();
    logic [82:0] x;
    x[82]    = ($urandom_range(0, 4) != 0);
    x[81:63] = vpool[$urandom_range(0, 3)];
    x[62]    = ($urandom_range(0, 3) == 0);
    x[61:52] = apool[$urandom_range(0, 3)];
    x[51:32] = 20'($urandom);
    x[31:0]  = $urandom;
    return x;
  endfunction

  task automatic wr(input int idx, input logic [82:0] ent);
    bus.wr_en    = 1'b1;
    bus.wr_idx   = IW'(idx);
    bus.wr_entry = ent;
    @(negedge clk);
    bus.wr_en = 1'b0;
    m_ent[idx] = ent;
  endtask

  task automatic look(input logic [31:0] va, input logic [9:0] asid, input string nm);
    logic [30:0] exp;
    exp = ref_lookup(va, asid);
    bus.req_valid = 1'b1;
    bus.req_vaddr = va;
    bus.req_asid  = asid;
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b1 || dut_rsp !== exp)
      $display("FAIL %s: got valid=%b rsp=%h, expected valid=1 rsp=%h", nm, bus.rsp_valid, dut_rsp, exp);
    else passed++;
  endtask

  task automatic clear_table();
    for (int i = 0; i < N; i++) wr(i, 83'd0);
  endtask

  // Counts busy cycles after a start; also verifies req_ready and that no request is answered.
  task automatic count_busy(input string nm, input int poke_at, output int cnt);
    int bad, guard;
    cnt = 0; bad = 0; guard = 0;
    while (bus.inv_busy === 1'b1 && guard < 64) begin
      cnt++;
      if (bus.req_ready !== 1'b0) bad++;
      bus.req_valid = 1'b1;
      bus.inv_valid = (cnt == poke_at);
      bus.inv_op    = 3'd0;
      @(negedge clk);
      bus.inv_valid = 1'b0;
      if (bus.rsp_valid !== 1'b0) bad++;
      guard++;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (cnt != N || bad != 0)
      $display("FAIL %s: busy cycles=%0d bad ready/rsp=%0d, expected busy cycles=%0d bad=0", nm, cnt, bad, N);
    else passed++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.req_valid = 0; bus.req_vaddr = 0; bus.req_asid = 0;
    bus.wr_en = 0; bus.wr_idx = 0; bus.wr_entry = 0;
    bus.inv_valid = 0; bus.inv_op = 0; bus.inv_asid = 0; bus.inv_vppn = 0;
    for (int i = 0; i < N; i++) m_ent[i] = 83'd0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 0 || bus.req_ready !== 1 || bus.inv_busy !== 0 || dut_rsp !== 0)
      $display("FAIL reset: valid=%b ready=%b busy=%b rsp=%h, expected 0 1 0 0",
               bus.rsp_valid, bus.req_ready, bus.inv_busy, dut_rsp);
    else passed++;
    look(32'h2468A000, 10'h005, "reset_miss");
  endtask

  task automatic test_basic_hit();
    wr(3, mk(1'b1, 19'h12345, 1'b0, 10'h005, {20'hAAAAA, 1'b1, 1'b0, 2'b01, 2'b00},
                                             {20'hBBBBB, 1'b1, 1'b1, 2'b10, 2'b11}));
    look(32'h2468A000, 10'h005, "basic_page0");
    checks++;
    if (bus.rsp_hit !== 1 || bus.rsp_idx !== 4'd3 || bus.rsp_pfn !== 20'hAAAAA)
      $display("FAIL basic_fields: hit=%b idx=%0d pfn=%h, expected 1 3 AAAAA", bus.rsp_hit, bus.rsp_idx, bus.rsp_pfn);
    else passed++;
    look(32'h2468B000, 10'h005, "basic_page1");
    checks++;
    if (bus.rsp_pfn !== 20'hBBBBB)
      $display("FAIL basic_pfn1: pfn=%h, expected BBBBB", bus.rsp_pfn);
    else passed++;
  endtask

  task automatic test_asid_global();
    look(32'h2468A000, 10'h006, "asid_miss");
    checks++;
    if (bus.rsp_hit !== 0 || bus.rsp_pfn !== 0)
      $display("FAIL asid_miss_fields: hit=%b pfn=%h, expected 0 0", bus.rsp_hit, bus.rsp_pfn);
    else passed++;
    wr(3, mk(1'b1, 19'h12345, 1'b1, 10'h006, {20'hAAAAA, 1'b1, 1'b0, 2'b01, 2'b00},
                                             {20'hBBBBB, 1'b1, 1'b1, 2'b10, 2'b11}));
    look(32'h2468A000, 10'h006, "global_asid6");
    look(32'h2468B000, 10'h009, "global_other_asid");
  endtask

  task automatic test_priority_b2b();
    logic [82:0] e;
    logic [31:0] va [4];
    logic [9:0]  as [4];
    logic [30:0] exp [4];
    e = mk(1'b1, 19'h00777, 1'b0, 10'h0AA, {20'h11111, 4'hF, 2'b01}, {20'h22222, 4'h5, 2'b10});
    wr(2, e);
    wr(9, e);
    va[0] = {19'h00777, 13'h0000}; as[0] = 10'h0AA;
    va[1] = {19'h00777, 13'h1000}; as[1] = 10'h0AA;
    va[2] = {19'h12345, 13'h0000}; as[2] = 10'h006;
    va[3] = {19'h00777, 13'h0000}; as[3] = 10'h0AB;
    for (int k = 0; k < 4; k++) begin
      exp[k] = ref_lookup(va[k], as[k]);
      bus.req_valid = 1'b1;
      bus.req_vaddr = va[k];
      bus.req_asid  = as[k];
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || dut_rsp !== exp[k])
        $display("FAIL b2b_%0d: valid=%b rsp=%h, expected valid=1 rsp=%h", k, bus.rsp_valid, dut_rsp, exp[k]);
      else passed++;
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0 || dut_rsp !== exp[3])
      $display("FAIL b2b_hold: valid=%b rsp=%h, expected valid=0 rsp=%h", bus.rsp_valid, dut_rsp, exp[3]);
    else passed++;
    checks++;
    if (exp[0][29:26] !== 4'd2)
      $display("FAIL priority_model: idx=%0d, expected 2", exp[0][29:26]);
    else passed++;
  endtask

  task automatic test_random();
    logic [30:0] exp, last;
    logic [82:0] went;
    logic [31:0] va;
    logic [9:0]  as;
    bit do_wr, do_rq;
    int wi;
    last = '0;
    for (int it = 0; it < 300; it++) begin
      do_wr = ($urandom_range(0, 9) < 3);
      do_rq = (it == 0) || ($urandom_range(0, 9) < 7);
      wi    = $urandom_range(0, N - 1);
      went  = rand_ent();
      va    = {vpool[$urandom_range(0, 3)], 1'($urandom), 12'($urandom)};
      as    = apool[$urandom_range(0, 3)];
      exp   = ref_lookup(va, as);
      bus.wr_en = do_wr; bus.wr_idx = IW'(wi); bus.wr_entry = went;
      bus.req_valid = do_rq; bus.req_vaddr = va; bus.req_asid = as;
      @(negedge clk);
      bus.wr_en = 1'b0; bus.req_valid = 1'b0;
      if (do_wr) m_ent[wi] = went;
      if (do_rq) last = exp;
      checks++;
      if (bus.rsp_valid !== do_rq || dut_rsp !== last)
        $display("FAIL random_%0d: valid=%b rsp=%h, expected valid=%b rsp=%h", it, bus.rsp_valid, dut_rsp, do_rq, last);
      else passed++;
    end
  endtask

  task automatic test_inv_op5();
    logic [18:0] x;
    logic [30:0] exp;
    int cnt;
    x = 19'h0ABCD;
    clear_table();
    wr(1, mk(1'b1, x, 1'b0, 10'h007, {20'h00001, 6'h20}, {20'h00011, 6'h20}));
    wr(4, mk(1'b1, x, 1'b1, 10'h007, {20'h00004, 6'h20}, {20'h00044, 6'h20}));
    wr(6, mk(1'b1, x, 1'b0, 10'h008, {20'h00006, 6'h20}, {20'h00066, 6'h20}));
    exp = ref_lookup({x, 13'h0}, 10'h007);
    bus.inv_valid = 1'b1; bus.inv_op = 3'd5; bus.inv_asid = 10'h007; bus.inv_vppn = x;
    bus.req_valid = 1'b1; bus.req_vaddr = {x, 13'h0}; bus.req_asid = 10'h007;
    @(negedge clk);
    bus.inv_valid = 1'b0; bus.req_valid = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b1 || dut_rsp !== exp || bus.inv_busy !== 1'b1)
      $display("FAIL inv5_pre: valid=%b rsp=%h busy=%b, expected 1 %h 1", bus.rsp_valid, dut_rsp, bus.inv_busy, exp);
    else passed++;
    count_busy("inv5_busy", 0, cnt);
    model_inv(3'd5, 10'h007, x);
    look({x, 13'h0}, 10'h007, "inv5_idx1_gone");
    look({x, 13'h0}, 10'h009, "inv5_idx4_kept");
    look({x, 13'h1000}, 10'h008, "inv5_idx6_kept");
  endtask

  task automatic test_ignored();
    int bad, cnt;
    bad = 0;
    bus.inv_valid = 1'b1; bus.inv_op = 3'd7;
    @(negedge clk);
    bus.inv_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.inv_busy !== 1'b0 || bus.req_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) $display("FAIL op7_nop: busy seen %0d cycles, expected 0", bad);
    else passed++;
    look({19'h0ABCD, 13'h0}, 10'h009, "op7_table_intact");
    // op 3 sweep with an op 0 poke mid-sweep; g=1 entry 4 must survive
    bus.inv_valid = 1'b1; bus.inv_op = 3'd3; bus.inv_asid = 10'h0; bus.inv_vppn = 19'h0;
    @(negedge clk);
    bus.inv_valid = 1'b0;
    count_busy("midsweep_busy", 4, cnt);
    model_inv(3'd3, 10'h0, 19'h0);
    look({19'h0ABCD, 13'h0}, 10'h009, "midsweep_ignored");
  endtask

  task automatic test_random_inv();
    logic [2:0]  op;
    logic [9:0]  ia;
    logic [18:0] iv;
    logic [82:0] e;
    int cnt;
    for (int r = 0; r < 7; r++) begin
      for (int i = 0; i < N - 1; i++) wr(i, rand_ent());
      op = 3'(r);
      ia = apool[$urandom_range(0, 3)];
      iv = vpool[$urandom_range(0, 3)];
      e  = rand_ent();
      bus.wr_en = 1'b1; bus.wr_idx = IW'(N - 1); bus.wr_entry = e;
      bus.inv_valid = 1'b1; bus.inv_op = op; bus.inv_asid = ia; bus.inv_vppn = iv;
      @(negedge clk);
      bus.wr_en = 1'b0; bus.inv_valid = 1'b0;
      m_ent[N - 1] = e;
      count_busy("rinv_busy", 0, cnt);
      model_inv(op, ia, iv);
      for (int i = 0; i < N; i += 3)
        look({m_ent[i][81:63], 1'($urandom), 12'h0}, m_ent[i][61:52], "rinv_entry");
      look({m_ent[N-1][81:63], 13'h0}, m_ent[N-1][61:52], "rinv_last");
    end
  endtask

  task automatic test_reset_sweep();
    for (int i = 0; i < N; i++) wr(i, rand_ent());
    bus.inv_valid = 1'b1; bus.inv_op = 3'd2; bus.inv_asid = 10'h0; bus.inv_vppn = 19'h0;
    @(negedge clk);
    bus.inv_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (bus.inv_busy !== 0 || bus.rsp_valid !== 0 || bus.req_ready !== 1)
      $display("FAIL reset_in_sweep: busy=%b valid=%b ready=%b, expected 0 0 1", bus.inv_busy, bus.rsp_valid, bus.req_ready);
    else passed++;
    for (int i = 0; i < N; i++) m_ent[i][82] = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.inv_busy !== 0 || bus.rsp_valid !== 0 || dut_rsp !== 0)
      $display("FAIL post_reset: busy=%b valid=%b rsp=%h, expected 0 0 0", bus.inv_busy, bus.rsp_valid, dut_rsp);
    else passed++;
    for (int k = 0; k < 4; k++)
      for (int a = 0; a < 4; a++)
        look({vpool[k], 1'(a), 12'h0}, apool[a], "post_reset_miss");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_hit();
    test_asid_global();
    test_priority_b2b();
    test_random();
    test_inv_op5();
    test_ignored();
    test_random_inv();
    test_reset_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/tlb_lookup.md
# tlb_lookup

Registered TLB search stage that sits directly upstream of the address-translation block and feeds it `pfn`. It holds `TLBNUM` fully-associative LoongArch-style double-page entries (4 KiB pages only) and answers one lookup per cycle with one-cycle latency. It also services entry writes (TLBWR/TLBFILL) and runs an INVTLB sweep state machine that walks all entries.

## Interface
- `TLBNUM`, 16: entry count, power of two, 2..64.
- `IDX_W`, $clog2(TLBNUM): index width.

Clock and reset are one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock
- `resetn`  in  1  asynchronous active-low reset
- `req_valid`  in  1  lookup request
- `req_ready`  out  1  lookup can be accepted; equals `~inv_busy`
- `req_vaddr`  in  32  virtual address to translate
- `req_asid`  in  10  current ASID
- `rsp_valid`  out  1  lookup result valid, one-cycle pulse
- `rsp_hit`  out  1  matching entry found
- `rsp_idx`  out  IDX_W  index of the hit entry
- `rsp_pfn`  out  20  PPN of the selected page; goes to the translator's `pfn`
- `rsp_v`, `rsp_d`  out  1 each  valid and dirty bits of the selected page
- `rsp_mat`, `rsp_plv`  out  2 each  memory type and privilege of the selected page
- `wr_en`  in  1  write an entry
- `wr_idx`  in  IDX_W  entry to write
- `wr_entry`  in  83  entry payload, bits listed high to low:
  - [82] e
  - [81:63] vppn
  - [62] g
  - [61:52] asid
  - [51:32] ppn0, [31] v0, [30] d0, [29:28] mat0, [27:26] plv0
  - [25:6] ppn1, [5] v1, [4] d1, [3:2] mat1, [1:0] plv1
- `inv_valid`  in  1  start an INVTLB
- `inv_op`  in  3  INVTLB op code
- `inv_asid`  in  10  ASID operand
- `inv_vppn`  in  19  VA[31:13] operand
- `inv_busy`  out  1  sweep in progress

## Operation
- **Match.** Entry i matches when all of the following hold:
  - e=1
  - vppn == `req_vaddr[31:13]`
  - g=1 or asid == `req_asid`
- **Page select.** `req_vaddr[12]` selects page 1, otherwise page 0.
- **Multiple matches.** The lowest index wins. Multiple matches are not an error.
- **Miss.** `rsp_hit`=0, and `rsp_idx`, `rsp_pfn`, `rsp_v`, `rsp_d`, `rsp_mat`, `rsp_plv` are all 0.
- **Lookup vs. write.** The comparison uses entry state before the clock edge. A write or invalidate committing in the same cycle is not visible to that lookup.
- **Write.** On `wr_en` with `inv_busy`=0, entry `wr_idx` is replaced at the edge. `wr_en` while `inv_busy`=1 is dropped; the upstream must not issue it.
- **INVTLB state machine, IDLE -> SWEEP -> IDLE.**
  - IDLE: `inv_valid` with a legal op latches op, asid and vppn, clears the counter, and goes to SWEEP.
  - Op 7 is a no-op: no sweep and no busy.
  - SWEEP: in cycle k, entry k has e cleared if the condition holds. After k = TLBNUM-1 it returns to IDLE.
  - `inv_valid` during SWEEP is ignored.
- **Invalidate conditions per op.**
  - 0, 1: all entries.
  - 2: g=1.
  - 3: g=0.
  - 4: g=0 and asid==inv_asid.
  - 5: g=0, asid==inv_asid and vppn==inv_vppn.
  - 6: (g=1 or asid==inv_asid) and vppn==inv_vppn.
- **Sweep vs. write.** If `wr_en` and an `inv_valid` start coincide in IDLE, the write commits first. The sweep then evaluates the newly written contents of entry k in cycle k.
- **Reset.**
  - All e=0; other entry fields are don't-care.
  - State IDLE, counter 0.
  - All outputs 0 except `req_ready`=1.
  - Reset during SWEEP aborts the sweep; all entries are invalid afterwards.

## Timing
- A request accepted in cycle N (`req_valid`&`req_ready`) gives `rsp_*` valid in cycle N+1.
- `rsp_valid` is high for exactly one cycle per accepted request. Throughput is 1 per cycle with no response backpressure.
- `rsp_*` fields hold their last value while `rsp_valid`=0.
- `inv_valid` accepted in cycle N:
  - `inv_busy` is high in cycles N+1 .. N+TLBNUM.
  - Entry k is cleared at the end of cycle N+1+k.
  - `req_ready` is low over the same window.
- A lookup may be accepted in cycle N itself, and it sees the pre-invalidate state.
- A lookup accepted in the cycle after `inv_busy` falls sees the fully swept table.

## Test plan
- **Basic hit.** Write idx 3 with e=1, vppn=0x12345, g=0, asid=0x05, ppn0=0xAAAAA, ppn1=0xBBBBB, v0=v1=1. Look up VA 0x2468A000, asid 5 -> next cycle hit=1, idx=3, pfn=0xAAAAA. Look up VA 0x2468B000 -> pfn=0xBBBBB.
- **ASID miss and global match.** Same entry, asid 6 -> hit=0, pfn=0. Rewrite with g=1, asid 6 -> hit=1.
- **Priority and back-to-back.** Identical entries at idx 2 and 9 -> idx=2. Four back-to-back requests give four consecutive `rsp_valid` pulses.
- **INVTLB op 5 sweep.** Set up entries: idx 1 (g=0, asid 7, vppn X), idx 4 (g=1, vppn X), idx 6 (g=0, asid 8, vppn X). Issue op 5, asid 7, vppn X -> `inv_busy` high for exactly 16 cycles and `req_ready` low. Afterwards: idx 1 misses, idx 4 and idx 6 still hit.
- **Ignored and no-op ops.** `inv_valid` with op 7 -> `inv_busy` stays 0. `inv_valid` mid-SWEEP -> no extension or restart.
- **Reset during sweep.** Deassert `resetn` at sweep cycle 5, then release -> every lookup misses, `inv_busy`=0, `rsp_valid`=0, `req_ready`=1.
